// File: rtl/sap_pkg.sv
// Shared definitions for the SAP program loader: RAM geometry and loader state encoding.
package sap_pkg;

    localparam int unsigned SAP_ADDR_W    = 4;
    localparam int unsigned SAP_DATA_W    = 8;
    localparam int unsigned SAP_RAM_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/sap_prog_loader.sv
// Loads a framed, checksummed byte stream into the SAP program RAM and holds
// the CPU in reset until a complete, valid image has been written.
module sap_prog_loader
    import sap_pkg::*;
#(
    parameter int unsigned ADDR_W = SAP_ADDR_W,
    parameter int unsigned DATA_W = SAP_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                beat;
    logic [DATA_W-1:0]   chk_sum;
    logic [CNT_W-1:0]    cnt_inc;

    assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign beat     = in_valid & in_ready;
    assign chk_sum  = acc_q + in_data;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        acc_d       = acc_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_HDR;
                    cpu_hold_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cnt_d      = '0;
                    acc_d      = '0;
                end
            end
            ST_HDR: begin
                // A zero header encodes a full-depth image
                if (beat) begin
                    if (in_data > DATA_W'(DEPTH)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                        len_d   = (in_data == '0) ? CNT_W'(DEPTH) : CNT_W'(in_data);
                    end
                end
            end
            ST_DATA: begin
                if (beat) begin
                    acc_d       = chk_sum;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = cnt_q[ADDR_W-1:0];
                    ram_wdata_d = in_data;
                    cnt_d       = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (beat) begin
                    busy_d = 1'b0;
                    if (chk_sum == '0) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/sap_prog_loader.md
Name: sap_prog_loader

Overview:
Writer side of the SAP program RAM. The block accepts a framed byte stream (header, program words, checksum) over a valid/ready handshake. It writes each program word into the 16x8 program RAM and holds the SAP CPU in reset until a complete, checksum-valid image is loaded. It sits between the host/debug byte source and the RAM write port, with its cpu_hold output gating the CPU reset.

Parameters:
ADDR_W, 4, RAM address width; RAM depth = 2^ADDR_W words
DATA_W, 8, RAM word width and stream byte width

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a new load
in_valid  input  1  stream byte valid
in_data  input  DATA_W  stream byte
in_ready  output  1  block accepts a byte this cycle
ram_we  output  1  RAM write strobe, one cycle per word
ram_addr  output  ADDR_W  RAM write address
ram_wdata  output  DATA_W  RAM write data
cpu_hold  output  1  1 = hold SAP CPU in reset
busy  output  1  load in progress
done  output  1  last load succeeded
error  output  1  last load failed (bad header or checksum)

Behaviour:
- Reset (async, active-high): state IDLE; in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=1, busy=0, done=0, error=0; word counter and checksum accumulator = 0.
- Beat: a byte transfers when in_valid & in_ready on a rising edge. in_ready is combinational from state: 1 in HDR, DATA, CHK; 0 otherwise.
- Frame format: header byte N, then N data bytes, then checksum byte C. N=0 means 2^ADDR_W words. N > 2^ADDR_W is an error. A frame is valid when (sum of data bytes + C) mod 2^DATA_W = 0.
- IDLE: on start -> HDR. On the same edge: cpu_hold=1, busy=1, done=0, error=0, counter=0, accumulator=0.
- HDR: on a beat, latch N (0 -> 2^ADDR_W). If N is legal -> DATA; otherwise -> ERR.
- DATA: each beat adds the byte to the accumulator (wraps mod 2^DATA_W). On the next cycle, ram_we=1 with ram_addr=counter and ram_wdata=byte (registered, latency 1). The counter then increments. After the Nth beat -> CHK. Back-to-back beats produce back-to-back writes at consecutive addresses.
- CHK: on a beat, compare (accumulator + C) mod 2^DATA_W with 0.
  - Equal -> DONE: done=1, cpu_hold=0, busy=0.
  - Not equal -> ERR: error=1, cpu_hold stays 1, busy=0.
- DONE / ERR: outputs stay stable until start, which restarts as from IDLE. In DONE, start re-asserts cpu_hold on the same edge.
- start while busy (HDR/DATA/CHK) is ignored.
- in_valid outside HDR/DATA/CHK is ignored; no byte is consumed.
- Stalls: in_valid low for any number of cycles does not change state.
- RAM contents written before an error are left in place; cpu_hold guarantees they are never executed.
- Reset mid-load aborts immediately, with cpu_hold=1. A pending ram_we is dropped.
- ram_addr never exceeds N-1. No wrap occurs within a frame.

Decomposition:
- Shared package sap_pkg:
  - state encoding enum (IDLE, HDR, DATA, CHK, DONE, ERR)
  - constants SAP_ADDR_W=4, SAP_DATA_W=8, SAP_RAM_DEPTH=16
- A single module; no sub-module is needed. The checksum accumulator is inline.

Test Plan:
- Reset, then start; frame N=4, data 0x1E,0x2F,0xE0,0xF0, C=0xE3, in_valid held high -> four writes on consecutive cycles at addr 0..3; then done=1, cpu_hold=0, error=0.
- Same frame with C=0xE4 -> four writes occur; error=1, done=0, cpu_hold=1.
- Header N=0x11 -> ERR right after the header beat; no ram_we; error=1, cpu_hold=1.
- Header N=0 with 16 bytes 0x01 and C=0xF0 -> sixteen writes at addr 0..15; done=1.
- Random in_valid gaps plus start pulses mid-DATA -> writes unaffected, start ignored, same final result as the gap-free run.
- Assert reset during the DATA beat for addr 2 -> all outputs return to reset values asynchronously; no ram_we for addr 2; a fresh start with a valid frame then succeeds.
